priv_trap_redirect: RTL and testbench
=====================================

Name: priv_trap_redirect

Overview:
- Sequencer directly downstream of the interrupt/exception handler in the privilege block (v1.13).
- Consumes the trap and return requests: intr, intr_to_s, mret and sret.
- Waits until the pipeline is safe to redirect, then issues a one-cycle PC redirect (insert_pc, priv_pc) to the fetch stage.
- Owns the current privilege-mode register and its one-hot decodes; pmp, csr and int_ex_handler consume these.

Parameters:
- RESET_PRIV, 2'b11: privilege level after reset (M-mode).
- VECTORED_EN, 1: 1 enables vectored tvec mode for interrupts; 0 forces direct mode.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- intr  input  1  trap request from int_ex_handler.
- intr_to_s  input  1  trap is delegated to S-mode (valid with intr).
- mret  input  1  MRET reached commit.
- sret  input  1  SRET reached commit.
- pipe_clear  input  1  pipeline free of hazards.
- ex_mem_stall  input  1  EX/MEM stage stalled.
- curr_mtvec  input  32  {base[31:2], mode[1:0]}.
- curr_stvec  input  32  {base[31:2], mode[1:0]}.
- next_mcause  input  32  {interrupt[31], code[30:0]}.
- next_scause  input  32  {interrupt[31], code[30:0]}.
- curr_mepc  input  32  M return address.
- curr_sepc  input  32  S return address.
- curr_mstatus  input  32  uses MPP[12:11] and SPP[8].
- insert_pc  output  1  one-cycle redirect strobe.
- priv_pc  output  32  redirect target; valid while insert_pc=1.
- curr_privilege_level  output  2  U=00, S=01, M=11.
- isUMode, isSMode, isMMode  output  1 each  one-hot decode of curr_privilege_level.
- busy  output  1  high in WAIT_CLEAR or REDIRECT.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, insert_pc=0, priv_pc=0, busy=0.
  - curr_privilege_level=RESET_PRIV, with isMMode=1 and isUMode=isSMode=0 for the default RESET_PRIV.
  - Reset asserted mid-operation discards any pending request. No redirect is issued after reset releases.
- States:
  - IDLE: accepts a request. Priority is intr > mret > sret; a lower-priority request in the same cycle is dropped.
  - On accept, latch the target and the next privilege.
    - If pipe_clear=1 and ex_mem_stall=0 in the same cycle, go to REDIRECT.
    - Otherwise go to WAIT_CLEAR.
  - WAIT_CLEAR:
    - Go to REDIRECT on the first cycle with pipe_clear=1 and ex_mem_stall=0.
    - An intr arriving here while the pending request is an mret or sret replaces it: relatch the target and privilege, then apply the same exit test that cycle.
    - Any other new request is ignored.
  - REDIRECT: insert_pc=1 for exactly this one cycle, priv_pc holds the latched target, then unconditionally go to IDLE. Requests are ignored in this cycle.
- Latency: accept at cycle N with a clear pipe gives insert_pc=1 in cycle N+1. insert_pc is never high in two consecutive cycles.
- Target computation, latched at accept and using the tvec/cause/epc values sampled at accept:
  - intr with intr_to_s=0: tvec=curr_mtvec, cause=next_mcause. intr_to_s=1: tvec=curr_stvec, cause=next_scause.
  - If VECTORED_EN=1, tvec mode=01 and cause[31]=1: target = {base,2'b00} + {cause[29:0],2'b00}, modulo 2^32.
  - Otherwise (mode 00, 10 or 11 included): target = {base,2'b00}.
  - mret: target = {curr_mepc[31:2],2'b00}. sret: target = {curr_sepc[31:2],2'b00}.
- Next privilege, latched at accept:
  - intr with intr_to_s=0 -> M. intr with intr_to_s=1 -> S.
  - mret -> MPP, where reserved MPP=10 maps to U.
  - sret -> S if SPP=1, else U.
- Privilege update:
  - curr_privilege_level is loaded on the edge entering REDIRECT, so the new mode is visible in the same cycle as insert_pc=1.
  - The one-hot decodes are combinational from the register.

Test Plan:
- Reset: nRST low mid-WAIT_CLEAR -> insert_pc=0, level=11, isMMode=1, no redirect after release.
- Direct M trap: mtvec=0x8000_0100, intr=1, pipe_clear=1, stall=0 at cycle N -> insert_pc=1 at N+1 with priv_pc=0x8000_0100, level=11; insert_pc=0 at N+2.
- Vectored interrupt: mtvec=0x8000_0001, next_mcause=0x8000_0007 -> priv_pc=0x8000_001C. Same setup with cause=0x0000_0002 -> priv_pc=0x8000_0000.
- Stall wait: intr_to_s=1, stvec=0x0000_2000, ex_mem_stall high 3 cycles -> busy=1 throughout, single insert_pc after the stall drops, priv_pc=0x2000, level=01.
- Returns: mret with MPP=00, mepc=0x0000_1236 -> priv_pc=0x0000_1234, level=00. sret with SPP=1, sepc=0x4000 -> priv_pc=0x4000, level=01.
- Preemption: mret pending in WAIT_CLEAR, then intr (mtvec=0x100) -> single redirect to 0x100, level=11; same-cycle intr+mret in IDLE -> trap wins.

Source files
------------

// File: rtl/priv_trap_redirect.sv
// Trap/return redirect sequencer: latches the PC target and next privilege for a trap, MRET or SRET,
// waits for a safe pipeline, then issues a single-cycle redirect while owning the privilege register.
module priv_trap_redirect #(
    parameter logic [1:0] RESET_PRIV  = 2'b11,
    parameter int         VECTORED_EN = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        intr,
    input  logic        intr_to_s,
    input  logic        mret,
    input  logic        sret,
    input  logic        pipe_clear,
    input  logic        ex_mem_stall,
    input  logic [31:0] curr_mtvec,
    input  logic [31:0] curr_stvec,
    input  logic [31:0] next_mcause,
    input  logic [31:0] next_scause,
    input  logic [31:0] curr_mepc,
    input  logic [31:0] curr_sepc,
    input  logic [31:0] curr_mstatus,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic [1:0]  curr_privilege_level,
    output logic        isUMode,
    output logic        isSMode,
    output logic        isMMode,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_CLEAR = 2'b01,
        REDIRECT   = 2'b10
    } state_t;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [1:0]  npriv_q, npriv_d;
    logic        pend_trap_q, pend_trap_d;
    logic [1:0]  priv_q, priv_d;
    logic        safe;

    function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (VECTORED_EN != 0 && tvec[1:0] == 2'b01 && cause[31])
            return base + {cause[29:0], 2'b00};
        return base;
    endfunction

    // Reserved MPP encoding 2'b10 falls back to U-mode.
    function automatic logic [1:0] mret_priv(input logic [1:0] mpp);
        return (mpp == 2'b10) ? PRIV_U : mpp;
    endfunction

    function automatic logic [31:0] intr_target();
        return intr_to_s ? trap_target(curr_stvec, next_scause)
                         : trap_target(curr_mtvec, next_mcause);
    endfunction

    assign safe = pipe_clear & ~ex_mem_stall;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        npriv_d     = npriv_q;
        pend_trap_d = pend_trap_q;
        case (state_q)
            IDLE: begin
                if (intr) begin
                    target_d    = intr_target();
                    npriv_d     = intr_to_s ? PRIV_S : PRIV_M;
                    pend_trap_d = 1'b1;
                end else if (mret) begin
                    target_d    = {curr_mepc[31:2], 2'b00};
                    npriv_d     = mret_priv(curr_mstatus[12:11]);
                    pend_trap_d = 1'b0;
                end else if (sret) begin
                    target_d    = {curr_sepc[31:2], 2'b00};
                    npriv_d     = curr_mstatus[8] ? PRIV_S : PRIV_U;
                    pend_trap_d = 1'b0;
                end
                if (intr || mret || sret)
                    state_d = safe ? REDIRECT : WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
                // A trap may displace a pending return, never the reverse.
                if (intr && !pend_trap_q) begin
                    target_d    = intr_target();
                    npriv_d     = intr_to_s ? PRIV_S : PRIV_M;
                    pend_trap_d = 1'b1;
                end
                if (safe)
                    state_d = REDIRECT;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // New mode becomes visible together with the redirect strobe.
    always_comb begin
        priv_d = priv_q;
        if (state_d == REDIRECT && state_q != REDIRECT)
            priv_d = npriv_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            target_q    <= '0;
            npriv_q     <= RESET_PRIV;
            pend_trap_q <= 1'b0;
            priv_q      <= RESET_PRIV;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            npriv_q     <= npriv_d;
            pend_trap_q <= pend_trap_d;
            priv_q      <= priv_d;
        end
    end

    assign insert_pc            = (state_q == REDIRECT);
    assign priv_pc              = target_q;
    assign busy                 = (state_q == WAIT_CLEAR) || (state_q == REDIRECT);
    assign curr_privilege_level = priv_q;
    assign isUMode              = (priv_q == PRIV_U);
    assign isSMode              = (priv_q == PRIV_S);
    assign isMMode              = (priv_q == PRIV_M);

    logic unused_bits;
    assign unused_bits = ^{curr_mstatus[31:13], curr_mstatus[10:9], curr_mstatus[7:0],
                           next_mcause[30], next_scause[30], curr_mepc[1:0], curr_sepc[1:0]};

endmodule

// File: tb/tb_priv_trap_redirect.sv
// Scoreboard bench for priv_trap_redirect: each accepted request queues its expected redirect,
// and every insert_pc strobe pops and checks target, level and mode decodes.
module tb_priv_trap_redirect;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        intr, intr_to_s, mret, sret, pipe_clear, ex_mem_stall;
    logic [31:0] curr_mtvec, curr_stvec, next_mcause, next_scause;
    logic [31:0] curr_mepc, curr_sepc, curr_mstatus;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic [1:0]  curr_privilege_level;
    logic        isUMode, isSMode, isMMode, busy;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  lvl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_redirects = 0;
    int   n_pushed = 0;
    logic prev_ins = 1'b0;

    priv_trap_redirect dut (
        .CLK(CLK), .nRST(nRST), .intr(intr), .intr_to_s(intr_to_s), .mret(mret), .sret(sret),
        .pipe_clear(pipe_clear), .ex_mem_stall(ex_mem_stall),
        .curr_mtvec(curr_mtvec), .curr_stvec(curr_stvec),
        .next_mcause(next_mcause), .next_scause(next_scause),
        .curr_mepc(curr_mepc), .curr_sepc(curr_sepc), .curr_mstatus(curr_mstatus),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .curr_privilege_level(curr_privilege_level),
        .isUMode(isUMode), .isSMode(isSMode), .isMMode(isMMode), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [1:0] lvl);
        exp_t e;
        e.pc  = pc;
        e.lvl = lvl;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    always @(negedge CLK) begin
        if (nRST && insert_pc) begin
            exp_t e;
            n_redirects++;
            chk("no_back_to_back", {31'd0, prev_ins}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", priv_pc, 32'hDEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                chk("priv_pc", priv_pc, e.pc);
                chk("level", {30'd0, curr_privilege_level}, {30'd0, e.lvl});
                chk("onehot", {29'd0, isMMode, isSMode, isUMode},
                    {29'd0, e.lvl == 2'b11, e.lvl == 2'b01, e.lvl == 2'b00});
                chk("busy_redirect", {31'd0, busy}, 32'd1);
            end
        end
        prev_ins = nRST ? insert_pc : 1'b0;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_reqs();
        intr = 0; intr_to_s = 0; mret = 0; sret = 0;
    endtask

    // Drive a request for one cycle (accepted on the next edge), then drop it.
    task automatic issue(input logic i, input logic its, input logic m, input logic s);
        intr = i; intr_to_s = its; mret = m; sret = s;
        step();
        clear_reqs();
    endtask

    // Wait up to n negedges for the redirect strobe.
    task automatic wait_insert(input string tag, input int n);
        bit seen = 0;
        for (int k = 0; k < n && !seen; k++) begin
            @(negedge CLK);
            if (insert_pc) seen = 1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
        step();
    endtask

    task automatic check_idle(input string tag);
        @(negedge CLK);
        chk({tag, "_ins"}, {31'd0, insert_pc}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        step();
    endtask

    initial begin
        int base_redirects;
        nRST = 0;
        clear_reqs();
        pipe_clear = 1; ex_mem_stall = 0;
        curr_mtvec = 0; curr_stvec = 0; next_mcause = 0; next_scause = 0;
        curr_mepc = 0; curr_sepc = 0; curr_mstatus = 0;
        step(); step();
        @(negedge CLK);
        chk("rst_ins", {31'd0, insert_pc}, 32'd0);
        chk("rst_pc", priv_pc, 32'd0);
        chk("rst_level", {30'd0, curr_privilege_level}, 32'd3);
        chk("rst_onehot", {29'd0, isMMode, isSMode, isUMode}, 32'b100);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step();
        nRST = 1;
        step();

        // Direct M trap with clear pipe: redirect exactly one cycle after accept.
        curr_mtvec = 32'h8000_0100; next_mcause = 32'h0000_000B;
        push_exp(32'h8000_0100, 2'b11);
        issue(1, 0, 0, 0);
        @(negedge CLK);
        chk("direct_lat_n1", {31'd0, insert_pc}, 32'd1);
        step();
        check_idle("direct_n2");

        // Vectored interrupt, then exception through the same vectored tvec.
        curr_mtvec = 32'h8000_0001; next_mcause = 32'h8000_0007;
        push_exp(32'h8000_001C, 2'b11);
        issue(1, 0, 0, 0);
        wait_insert("vec_intr_seen", 4);
        next_mcause = 32'h0000_0002;
        push_exp(32'h8000_0000, 2'b11);
        issue(1, 0, 0, 0);
        wait_insert("vec_exc_seen", 4);

        // S-mode trap held off by an EX/MEM stall for three cycles.
        curr_stvec = 32'h0000_2000; next_scause = 32'h0000_0005; ex_mem_stall = 1;
        push_exp(32'h0000_2000, 2'b01);
        issue(1, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            chk("stall_no_ins", {31'd0, insert_pc}, 32'd0);
            step();
        end
        ex_mem_stall = 0;
        @(negedge CLK);
        chk("stall_still_wait", {31'd0, insert_pc}, 32'd0);
        wait_insert("stall_seen", 4);
        check_idle("stall_after");

        // MRET to U with a misaligned mepc.
        curr_mstatus = 32'h0000_0000; curr_mepc = 32'h0000_1236;
        push_exp(32'h0000_1234, 2'b00);
        issue(0, 0, 1, 0);
        wait_insert("mret_u_seen", 4);

        // Reset in WAIT_CLEAR discards the pending trap.
        pipe_clear = 0;
        curr_mtvec = 32'h0000_0300;
        issue(1, 0, 0, 0);
        @(negedge CLK);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        step();
        nRST = 0;
        @(negedge CLK);
        chk("mid_rst_ins", {31'd0, insert_pc}, 32'd0);
        chk("mid_rst_level", {30'd0, curr_privilege_level}, 32'd3);
        chk("mid_rst_mmode", {31'd0, isMMode}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        pipe_clear = 1;
        base_redirects = n_redirects;
        nRST = 1;
        for (int k = 0; k < 4; k++) step();
        chk("no_redirect_after_rst", n_redirects, base_redirects);

        // SRET with SPP=1.
        curr_mstatus = 32'h0000_0100; curr_sepc = 32'h0000_4000;
        push_exp(32'h0000_4000, 2'b01);
        issue(0, 0, 0, 1);
        wait_insert("sret_seen", 4);

        // MRET with reserved MPP=10 lands in U.
        curr_mstatus = 32'h0000_1000; curr_mepc = 32'h0000_7008;
        push_exp(32'h0000_7008, 2'b00);
        issue(0, 0, 1, 0);
        wait_insert("mret_rsvd_seen", 4);

        // Pending MRET in WAIT_CLEAR is replaced by an incoming trap.
        pipe_clear = 0;
        curr_mstatus = 32'h0000_1800; curr_mepc = 32'h0000_5000;
        issue(0, 0, 1, 0);
        curr_mtvec = 32'h0000_0100; next_mcause = 32'h0000_0003;
        push_exp(32'h0000_0100, 2'b11);
        issue(1, 0, 0, 0);
        pipe_clear = 1;
        wait_insert("preempt_seen", 4);
        check_idle("preempt_single");

        // Same-cycle trap and MRET in IDLE: trap wins.
        curr_mtvec = 32'h0000_0200; curr_mepc = 32'h0000_6000; curr_mstatus = 32'h0;
        push_exp(32'h0000_0200, 2'b11);
        issue(1, 0, 1, 0);
        wait_insert("prio_seen", 4);
        check_idle("prio_single");

        chk("sb_empty", exp_q.size(), 0);
        chk("redirect_count", n_redirects, n_pushed);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
